// File: rtl/bc_sched_pkg.sv
// Shared types and helpers for the bit-count scheduler.
// State encoding, result/index width helpers and the watchdog slack
// used when BC_SCHED_TIMEOUT_EN is defined.
package bc_sched_pkg;

    // Sequencer states driving the shared bit-counter handshake.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Extra RUN cycles tolerated beyond DATA_W before the watchdog fires.
    localparam int TIMEOUT_SLACK = 4;

    // Bits needed to hold a population count of a data_w-bit operand.
    function automatic int res_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

    // Bits needed to index n requesters (never less than one).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : bc_sched_pkg

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after
// the pointer, wrapping modulo N_REQ. Purely combinational; the owner
// of the pointer register is the scheduler.
module rr_arbiter
    import bc_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic found;
    int   cand;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(pointer) + k) % N_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/bit_count_scheduler.sv
// Shares one bit-counter unit between N_REQ requesters.
// A round-robin arbiter picks a requester in IDLE; the sequencer then
// loads the operand (LOAD, start low), runs the unit (RUN, start high),
// captures the count on done and pulses ack to the owner (DRAIN).
// Optional feature macro: BC_SCHED_TIMEOUT_EN adds a RUN watchdog that
// completes the operation with result 0 and an err pulse.
module bit_count_scheduler
    import bc_sched_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int RES_W  = res_width(DATA_W)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic [RES_W-1:0]        result,
    output logic                    busy,
    output logic                    err,
    output logic                    bc_s,
    output logic [DATA_W-1:0]       bc_A,
    input  logic                    bc_done,
    input  logic [RES_W-1:0]        bc_result
);

    localparam int IDX_W = idx_width(N_REQ);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t              state_q,  state_d;
    logic [IDX_W-1:0]    ptr_q,    ptr_d;
    logic [IDX_W-1:0]    owner_q,  owner_d;
    logic [DATA_W-1:0]   bc_a_q,   bc_a_d;
    logic [RES_W-1:0]    result_q, result_d;
    logic [N_REQ-1:0]    ack_q,    ack_d;

`ifdef BC_SCHED_TIMEOUT_EN
    // Counter wide enough to reach the last RUN cycle before timeout.
    localparam int WD_W = $clog2(DATA_W + TIMEOUT_SLACK);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DATA_W + TIMEOUT_SLACK - 1);

    logic [WD_W-1:0]     wd_q,     wd_d;
    logic                err_q,    err_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration and operand selection
    // ------------------------------------------------------------------
    logic [N_REQ-1:0]    grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [DATA_W-1:0]   operand [N_REQ];
    logic [DATA_W-1:0]   masked  [N_REQ];
    logic [DATA_W-1:0]   grant_operand;
    logic [IDX_W-1:0]    ptr_after_grant;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req       (req),
        .pointer   (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Slice each requester's operand and mask it with its one-hot grant.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_operand
        assign operand[gi] = req_data[gi*DATA_W +: DATA_W];
        assign masked[gi]  = operand[gi] & {DATA_W{grant[gi]}};
    end

    // OR-reduce the masked operands: only the granted one is non-zero.
    always_comb begin
        grant_operand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            grant_operand = grant_operand | masked[k];
        end
    end

    // Pointer moves to the slot just past the winner, wrapping at N_REQ.
    always_comb begin
        ptr_after_grant = grant_idx + 1'b1;
        if (grant_idx == IDX_W'(N_REQ - 1)) begin
            ptr_after_grant = '0;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer next-state and register updates
    // ------------------------------------------------------------------
    // Next-state logic; ack and err default low so they are single-cycle pulses.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        bc_a_d   = bc_a_q;
        result_d = result_q;
        ack_d    = '0;
`ifdef BC_SCHED_TIMEOUT_EN
        wd_d     = wd_q;
        err_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    bc_a_d  = grant_operand;
                    owner_d = grant_idx;
                    ptr_d   = ptr_after_grant;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Start is low for this one cycle so the unit captures bc_A.
                state_d = RUN;
`ifdef BC_SCHED_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            RUN: begin
                if (bc_done) begin
                    result_d       = bc_result;
                    ack_d[owner_q] = 1'b1;
                    state_d        = DRAIN;
                end
`ifdef BC_SCHED_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    // Unit never answered: complete with a zero result.
                    result_d       = '0;
                    ack_d[owner_q] = 1'b1;
                    err_d          = 1'b1;
                    state_d        = DRAIN;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            DRAIN: begin
                // Start is low again, letting the unit return to idle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Core sequencer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            bc_a_q   <= '0;
            result_q <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            bc_a_q   <= bc_a_d;
            result_q <= result_d;
            ack_q    <= ack_d;
        end
    end

`ifdef BC_SCHED_TIMEOUT_EN
    // Watchdog counter and error pulse register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs: registered values or direct state decodes
    // ------------------------------------------------------------------
    assign bc_s   = (state_q == RUN);
    assign busy   = (state_q != IDLE);
    assign bc_A   = bc_a_q;
    assign ack    = ack_q;
    assign result = result_q;

endmodule : bit_count_scheduler
